// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: clear, skewed feed window,
// row-by-row result drain over a valid/ready port, then a one-cycle done pulse.
module systolic_seq_ctrl #(
  parameter  int N     = 4,
  parameter  int K_MAX = 16,
  localparam int KW    = $clog2(K_MAX + 1),
  localparam int RW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          acc_clr,
  output logic          pe_en,
  output logic [N-1:0]  lane_vld,
  output logic [N*KW-1:0] lane_k,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_row,
  output logic [2:0]    dbg_state
);

  // Feed counter must hold up to K_MAX + 2N - 3 without wrapping.
  localparam int FW = $clog2(K_MAX + 2 * N - 1);

  localparam logic [KW-1:0] K_MAX_W  = KW'(K_MAX);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [FW-1:0] SKEW_W   = FW'(2 * N - 3);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] f, f_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [KW-1:0] k_lat, k_lat_nxt;

  logic [FW-1:0] t_last;
  logic [FW:0]   f_ext;
  logic [FW:0]   k_ext;

  // Last feed index is T-1 = k_len + 2N - 3; only used while k_lat >= 1.
  assign t_last = FW'(k_lat) + SKEW_W;
  assign f_ext  = {1'b0, f};
  assign k_ext  = (FW+1)'(k_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      f     <= '0;
      row   <= '0;
      k_lat <= '0;
    end else begin
      state <= state_nxt;
      f     <= f_nxt;
      row   <= row_nxt;
      k_lat <= k_lat_nxt;
    end
  end

  // Result port: a row transfers in any cycle where res_valid and res_ready are both high;
  // res_valid stays up and res_row is held until that transfer happens.
  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    row_nxt   = row;
    k_lat_nxt = k_lat;
    case (state)
      IDLE: begin
        if (start) begin
          k_lat_nxt = (k_len > K_MAX_W) ? K_MAX_W : k_len;
          state_nxt = CLEAR;
          f_nxt     = '0;
          row_nxt   = '0;
        end
      end
      CLEAR: begin
        f_nxt     = '0;
        row_nxt   = '0;
        state_nxt = (k_lat != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (f == t_last) begin
          state_nxt = DRAIN;
          f_nxt     = '0;
          row_nxt   = '0;
        end else begin
          f_nxt = f + FW'(1);
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (row == ROW_LAST) begin
            state_nxt = DONE;
            row_nxt   = '0;
          end else begin
            row_nxt = row + RW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        f_nxt     = '0;
        row_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        f_nxt     = '0;
        row_nxt   = '0;
      end
    endcase
  end

  // Lane i sees element k = f - i, giving A rows and B columns the same diagonal skew.
  always_comb begin
    lane_vld = '0;
    lane_k   = '0;
    if (state == FEED) begin
      for (int i = 0; i < N; i++) begin
        if ((f_ext >= (FW+1)'(i)) && (f_ext < ((FW+1)'(i) + k_ext))) begin
          lane_vld[i]        = 1'b1;
          lane_k[i*KW +: KW] = KW'(f - FW'(i));
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign acc_clr   = (state == CLEAR);
  assign pe_en     = (state == FEED);
  assign res_valid = (state == DRAIN);
  assign res_row   = row;
  assign dbg_state = state;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl (N=4, K_MAX=16): directed jobs, per-cycle expected output
// snapshots queued by the driver and popped by an independent negedge monitor.
module tb_systolic_seq_ctrl;

  localparam int SW = 47;  // 16-bit cycle stamp + 31 bits of outputs

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  k_len;
  logic        busy, done, acc_clr, pe_en;
  logic [3:0]  lane_vld;
  logic [19:0] lane_k;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_row;
  logic [2:0]  dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int last_done_cyc = -1;

  logic [SW-1:0] exp_q[$];

  systolic_seq_ctrl #(.N(4), .K_MAX(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .acc_clr   (acc_clr),
    .pe_en     (pe_en),
    .lane_vld  (lane_vld),
    .lane_k    (lane_k),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_row   (res_row),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SW-1:0] snap(input int c, input bit b, input bit d, input bit clr,
                                         input bit pe, input logic [3:0] lv, input logic [19:0] lk,
                                         input bit rv, input int r);
    return {16'(c), b, d, clr, pe, lv, lk, rv, 2'(r)};
  endfunction

  // Expected timeline of one job started in cycle c0, following the documented latencies.
  task automatic build_exp(input int k, input int stall_row, input int stall_n, input int c0,
                           output int done_cyc, output int stall_c);
    int kk, t, d0, c;
    logic [3:0]  lv;
    logic [19:0] lk;
    kk = (k > 16) ? 16 : k;
    t  = (kk > 0) ? kk + 6 : 0;
    exp_q.push_back(snap(c0 + 1, 1, 0, 1, 0, 4'h0, 20'h0, 0, 0));
    for (int f = 0; f < t; f++) begin
      lv = '0;
      lk = '0;
      for (int i = 0; i < 4; i++) begin
        if (f >= i && f < i + kk) begin
          lv[i]          = 1'b1;
          lk[i*5 +: 5]   = 5'(f - i);
        end
      end
      exp_q.push_back(snap(c0 + 2 + f, 1, 0, 0, 1, lv, lk, 0, 0));
    end
    d0 = c0 + 2 + t;
    c  = d0;
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        for (int s = 0; s < stall_n; s++) begin
          exp_q.push_back(snap(c, 1, 0, 0, 0, 4'h0, 20'h0, 1, r));
          c++;
        end
      end
      exp_q.push_back(snap(c, 1, 0, 0, 0, 4'h0, 20'h0, 1, r));
      c++;
    end
    exp_q.push_back(snap(c, 1, 1, 0, 0, 4'h0, 20'h0, 0, 0));
    done_cyc = c;
    stall_c  = d0 + stall_row;
  endtask

  // Driver: called #1 after a posedge; returns #1 after the posedge that ends the done cycle.
  task automatic run_job(input int k, input int stall_row, input int stall_n,
                         input int feed_poke, input bit done_poke, input int exp_done_off);
    int c0, done_cyc, stall_c;
    c0 = cyc;
    last_done_cyc = -1;
    build_exp(k, stall_row, stall_n, c0, done_cyc, stall_c);
    for (int c = c0; c <= done_cyc; c++) begin
      start = (c == c0) || (feed_poke >= 0 && c == c0 + 2 + feed_poke) || (done_poke && c == done_cyc);
      k_len = (c == c0) ? 5'(k) : 5'd1;
      res_ready = !(stall_n > 0 && c >= stall_c && c < stall_c + stall_n);
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_ready = 1'b1;
    n_checks++;
    if (last_done_cyc - c0 != exp_done_off) begin
      n_errors++;
      $display("FAIL done_latency k=%0d: got %0d cycles after start, expected %0d", k, last_done_cyc - c0, exp_done_off);
    end
  endtask

  // Start a job, then hit rst rst_off cycles after start; the remaining timeline is discarded.
  task automatic run_reset(input int k, input int rst_off);
    int c0, done_cyc, stall_c;
    c0 = cyc;
    last_done_cyc = -1;
    build_exp(k, -1, 0, c0, done_cyc, stall_c);
    for (int c = c0; c < c0 + rst_off; c++) begin
      start = (c == c0);
      k_len = 5'(k);
      res_ready = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (last_done_cyc != -1) begin
      n_errors++;
      $display("FAIL reset_no_done: done seen in cycle %0d, expected none", last_done_cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [SW-1:0] act, e;
    act = {16'(cyc), busy, done, acc_clr, pe_en, lane_vld, lane_k, res_valid, res_row};
    if (busy) begin
      if (done) last_done_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_busy cycle %0d: got %h, expected idle outputs", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_errors++;
          $display("FAIL snapshot cycle %0d: got %h, expected %h", cyc, act, e);
        end
      end
    end else begin
      n_checks++;
      if (act[SW-17:0] !== '0) begin
        n_errors++;
        $display("FAIL idle_zero cycle %0d: got %h, expected 0", cyc, act[SW-17:0]);
      end
      if (exp_q.size() > 0 && int'(exp_q[0][SW-1 -: 16]) <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_snapshot cycle %0d: DUT idle, expected %h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_job(4, -1, 0, -1, 0, 16);   // T=10: done at +16
    repeat (2) @(posedge clk); #1;
    run_job(4, 1, 3, -1, 0, 19);    // 3 stall cycles on row 1
    run_job(0, -1, 0, -1, 0, 6);    // no feed window
    run_job(20, -1, 0, -1, 0, 28);  // clamped to 16, T=22
    run_job(2, -1, 0, 3, 1, 14);    // start pokes in FEED and DONE are ignored
    run_job(1, 3, 2, -1, 0, 15);    // accepted in the IDLE cycle right after DONE
    repeat (2) @(posedge clk); #1;
    run_reset(4, 5);                // rst during FEED
    run_job(3, 0, 1, -1, 0, 16);
    repeat (3) @(posedge clk); #1;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drained: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
